// File: rtl/display_source_arbiter_if.sv
// Bundles the four debug-tap sources, the control inputs and the display-side outputs
// of the display source arbiter. The arbiter takes the slave modport.
interface display_source_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data3;
    logic        auto_cycle;
    logic        freeze;
    logic [31:0] data_to_show;
    logic [3:0]  grant;
    logic [1:0]  src_id;
    logic        dwell_done;

    modport master (
        output req, data0, data1, data2, data3, auto_cycle, freeze,
        input  data_to_show, grant, src_id, dwell_done
    );

    modport slave (
        input  req, data0, data1, data2, data3, auto_cycle, freeze,
        output data_to_show, grant, src_id, dwell_done
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Round-robin arbiter sharing the seven-segment display between four 32-bit sources,
// giving each granted source a minimum dwell time before the display may move on.
module display_source_arbiter #(
    parameter int unsigned DWELL_TICKS = 32'd50000000,
    parameter logic [1:0]  RST_PTR     = 2'd3
) (
    input logic                     clk,
    input logic                     rst_n,
    display_source_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StShow} state_e;

    localparam logic [31:0] RELOAD = DWELL_TICKS - 32'd1;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_next;
    logic [1:0]  r_last;
    logic [1:0]  w_last_next;
    logic [1:0]  r_src;
    logic [1:0]  w_src_next;
    logic [3:0]  r_grant;
    logic [3:0]  w_grant_next;
    logic [31:0] r_data;
    logic [31:0] w_data_next;

    logic [3:0]  w_eff_req;
    logic [1:0]  w_choice;
    logic        w_found;
    logic [1:0]  w_idx;
    logic        w_others;
    logic [31:0] w_src_data;
    logic        w_done;

    assign w_eff_req = bus.auto_cycle ? 4'b1111 : bus.req;

    // Scan starts one past the last grant, so the last grantee is considered only last.
    always_comb begin
        w_choice = r_last;
        w_found  = 1'b0;
        w_idx    = r_last;
        for (int i = 1; i < 5; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && w_eff_req[w_idx]) begin
                w_choice = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // In SHOW the grant is one-hot at src, so masking it leaves only competing requests.
    assign w_others = |(w_eff_req & ~r_grant);

    always_comb begin
        w_src_data = bus.data0;
        unique case (r_src)
            2'd0: w_src_data = bus.data0;
            2'd1: w_src_data = bus.data1;
            2'd2: w_src_data = bus.data2;
            2'd3: w_src_data = bus.data3;
            default: w_src_data = bus.data0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_last_next  = r_last;
        w_src_next   = r_src;
        w_grant_next = r_grant;
        w_data_next  = r_data;
        w_done       = 1'b0;

        if (!bus.freeze) begin
            unique case (r_state)
                StIdle: begin
                    if (|w_eff_req) begin
                        w_state_next = StShow;
                        w_src_next   = w_choice;
                        w_last_next  = w_choice;
                        w_grant_next = 4'b0001 << w_choice;
                        w_cnt_next   = RELOAD;
                    end
                end
                StShow: begin
                    w_data_next = w_src_data;
                    if (r_cnt != 32'd0) begin
                        w_cnt_next = r_cnt - 32'd1;
                    end else begin
                        w_done = 1'b1;
                        if (w_others) begin
                            w_src_next   = w_choice;
                            w_last_next  = w_choice;
                            w_grant_next = 4'b0001 << w_choice;
                            w_cnt_next   = RELOAD;
                        end else if (w_eff_req[r_src]) begin
                            w_cnt_next = RELOAD;
                        end else begin
                            w_state_next = StIdle;
                            w_src_next   = 2'd0;
                            w_grant_next = 4'b0000;
                            w_data_next  = 32'd0;
                            w_cnt_next   = 32'd0;
                        end
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 32'd0;
            r_last  <= RST_PTR;
            r_src   <= 2'd0;
            r_grant <= 4'b0000;
            r_data  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_last  <= w_last_next;
            r_src   <= w_src_next;
            r_grant <= w_grant_next;
            r_data  <= w_data_next;
        end
    end

    assign bus.data_to_show = r_data;
    assign bus.grant        = r_grant;
    assign bus.src_id       = r_src;
    assign bus.dwell_done   = w_done;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_grant));
    a_grant_matches : assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == StShow) |-> r_grant[r_src]);

endmodule

// File: tb/tb_display_source_arbiter.sv
// Scoreboard bench: a cycle-level behavioural model predicts outputs for two arbiter
// instances (dwell 4 and dwell 2) driven by identical directed and random stimulus.
module tb_display_source_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_source_arbiter_if bus0 ();
    display_source_arbiter_if bus1 ();

    display_source_arbiter #(.DWELL_TICKS(4), .RST_PTR(2'd3)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    display_source_arbiter #(.DWELL_TICKS(2), .RST_PTR(2'd3)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct packed {
        logic [3:0]  grant;
        logic [1:0]  src;
        logic [31:0] data;
        logic        done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: cur = shown source or -1 when nothing is shown.
    int          cur  [2];
    int          rem  [2];
    int          last [2];
    logic [31:0] shown[2];
    int          dw   [2];

    logic [3:0]  s_req;
    logic        s_ac;
    logic        s_frz;
    logic        s_rst;
    logic [31:0] s_data[4];
    logic [31:0] fixed_data[4];
    bit          use_fixed = 1'b0;

    function automatic int rr_pick(logic [3:0] eff, int lst);
        for (int k = 1; k <= 4; k++) begin
            if (eff[(lst + k) % 4]) return (lst + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(input int m);
        exp_t       e;
        logic [3:0] eff;
        bit         other;
        eff = s_ac ? 4'hF : s_req;
        if (!s_rst) begin
            e = '0;
            cur[m] = -1; rem[m] = 0; last[m] = 3; shown[m] = 32'd0;
        end else begin
            e.grant = (cur[m] < 0) ? 4'h0 : 4'(1 << cur[m]);
            e.src   = (cur[m] < 0) ? 2'd0 : 2'(cur[m]);
            e.data  = shown[m];
            e.done  = (cur[m] >= 0) && (rem[m] == 0) && !s_frz;
            if (!s_frz) begin
                if (cur[m] < 0) begin
                    if (eff != 4'h0) begin
                        cur[m]  = rr_pick(eff, last[m]);
                        last[m] = cur[m];
                        rem[m]  = dw[m] - 1;
                    end
                end else begin
                    shown[m] = s_data[cur[m]];
                    if (rem[m] > 0) begin
                        rem[m]--;
                    end else begin
                        other = 1'b0;
                        for (int k = 0; k < 4; k++) if (k != cur[m] && eff[k]) other = 1'b1;
                        if (other) begin
                            cur[m]  = rr_pick(eff, last[m]);
                            last[m] = cur[m];
                            rem[m]  = dw[m] - 1;
                        end else if (eff[cur[m]]) begin
                            rem[m] = dw[m] - 1;
                        end else begin
                            cur[m]   = -1;
                            shown[m] = 32'd0;
                        end
                    end
                end
            end
        end
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive_bus;
        bus0.req = s_req; bus0.auto_cycle = s_ac; bus0.freeze = s_frz;
        bus1.req = s_req; bus1.auto_cycle = s_ac; bus1.freeze = s_frz;
        bus0.data0 = s_data[0]; bus0.data1 = s_data[1];
        bus0.data2 = s_data[2]; bus0.data3 = s_data[3];
        bus1.data0 = s_data[0]; bus1.data1 = s_data[1];
        bus1.data2 = s_data[2]; bus1.data3 = s_data[3];
    endtask

    // One clock of stimulus: inputs change 2 time units after the rising edge.
    task automatic cycle(input logic [3:0] req, input logic ac, input logic frz, input logic rst);
        @(posedge clk);
        #2;
        s_req = req; s_ac = ac; s_frz = frz; s_rst = rst;
        for (int i = 0; i < 4; i++) s_data[i] = use_fixed ? fixed_data[i] : $urandom;
        rst_n = rst;
        drive_bus();
        model_step(0);
        model_step(1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d4.grant", 32'(bus0.grant), 32'(e.grant));
            chk("d4.src_id", 32'(bus0.src_id), 32'(e.src));
            chk("d4.data_to_show", bus0.data_to_show, e.data);
            chk("d4.dwell_done", 32'(bus0.dwell_done), 32'(e.done));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d2.grant", 32'(bus1.grant), 32'(e.grant));
            chk("d2.src_id", 32'(bus1.src_id), 32'(e.src));
            chk("d2.data_to_show", bus1.data_to_show, e.data);
            chk("d2.dwell_done", 32'(bus1.dwell_done), 32'(e.done));
        end
    end

    initial begin
        dw[0] = 4; dw[1] = 2;
        for (int m = 0; m < 2; m++) begin
            cur[m] = -1; rem[m] = 0; last[m] = 3; shown[m] = 32'd0;
        end
        s_req = 4'h0; s_ac = 1'b0; s_frz = 1'b0; s_rst = 1'b0;
        for (int i = 0; i < 4; i++) s_data[i] = 32'd0;
        drive_bus();

        repeat (2) cycle(4'h0, 1'b0, 1'b0, 1'b0);

        // Single requester with a known word on source 2.
        fixed_data[0] = 32'h0; fixed_data[1] = 32'h0;
        fixed_data[2] = 32'h12345678; fixed_data[3] = 32'h0;
        use_fixed = 1'b1;
        repeat (14) cycle(4'b0100, 1'b0, 1'b0, 1'b1);

        // All four requesting: rotation with known words.
        fixed_data[0] = 32'hA; fixed_data[1] = 32'hB;
        fixed_data[2] = 32'hC; fixed_data[3] = 32'hD;
        repeat (24) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        use_fixed = 1'b0;

        // Let everything go idle, then a one-cycle request from source 1.
        repeat (6) cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0, 1'b1);
        repeat (8) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // Auto-scan with a 10-cycle freeze mid-dwell.
        repeat (6) cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        repeat (10) cycle(4'b0000, 1'b1, 1'b1, 1'b1);
        repeat (12) cycle(4'b0000, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset during source 2's dwell, then all request.
        repeat (7) cycle(4'b0100, 1'b0, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0, 1'b0, 1'b0);
        repeat (10) cycle(4'b1111, 1'b0, 1'b0, 1'b1);

        // Random traffic, including requests that change on expiry cycles.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r;
            r = 4'($urandom);
            cycle(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 149) != 0));
        end
        cycle(4'h0, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        n_checks++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/display_source_arbiter.md
Name: display_source_arbiter

Overview:
- Shares the 8-digit seven-segment display between four 32-bit data sources, e.g. PC, register file read port, memory data and cycle counter.
- Picks one source by round-robin and guarantees it a minimum dwell time on the display.
- Drives the registered 32-bit word into the display driver's data_to_show input.
- Sits between the CPU datapath debug taps and the display driver.

Parameters:
- DWELL_TICKS, default 50000000: minimum number of clk cycles a granted source stays displayed (1 s at 50 MHz). Legal range 2 to 2^32-1.
- RST_PTR, default 3: reset value of the last-granted pointer, so the first grant after reset goes to source 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  per-source display request, level sensitive
- data0  in  32  source 0 word
- data1  in  32  source 1 word
- data2  in  32  source 2 word
- data3  in  32  source 3 word
- auto_cycle  in  1  when 1, every source is treated as requesting (auto-scan mode)
- freeze  in  1  when 1, holds the current display, grant and dwell counter
- data_to_show  out  32  registered word to the display driver
- grant  out  4  one-hot grant; 0 when idle
- src_id  out  2  index of the granted source; 0 when idle
- dwell_done  out  1  one-cycle pulse on the cycle the dwell counter expires

Behaviour:
- Reset:
  - rst_n low asynchronously forces state=IDLE, data_to_show=0, grant=0, src_id=0, dwell_done=0, dwell counter=0, last pointer=RST_PTR.
  - The counter and pointer clear immediately; this applies mid-dwell as well.
- Effective request: eff_req = auto_cycle ? 4'b1111 : req.
- Round-robin choice: scan from (last+1) mod 4 upward, wrapping, and take the first set bit of eff_req.
- State IDLE:
  - grant=0, data_to_show=0.
  - If eff_req!=0 and freeze=0, the next clock edge enters SHOW with the chosen source. On that edge: grant and src_id are set, last=chosen, counter=DWELL_TICKS-1.
  - Latency from req rising to grant set is 1 cycle.
- State SHOW, freeze=0:
  - Every cycle, data_to_show <= data[src_id]. It tracks the live source with 1-cycle latency.
  - While counter!=0, the counter decrements. Deasserting the current req does NOT end the dwell early.
  - On the cycle counter==0:
    - dwell_done=1 for that cycle.
    - If eff_req has any bit set other than src_id, switch to the round-robin choice and reload the counter to DWELL_TICKS-1.
    - Else, if eff_req[src_id]=1, keep the grant and reload the counter.
    - Else, go to IDLE. data_to_show and grant are cleared on that same edge.
- freeze=1 in any state:
  - Counter, grant, src_id, state and data_to_show all hold their values.
  - dwell_done stays 0.
  - In IDLE, new requests are ignored while frozen.
- Simultaneous events:
  - freeze has priority over expiry.
  - A request arriving on the expiry cycle is eligible in that same cycle's choice.
  - auto_cycle toggling mid-dwell takes effect at the next expiry only.
- Invariants: grant is always one-hot or zero, and grant[src_id]=1 whenever state=SHOW.
- Counter width is 32 bits. The counter never underflows; the reload value is constant.

Test Plan (DWELL_TICKS=4 unless stated):
- Reset, then req=4'b0100 with data2=32'h12345678 → grant=4'b0100 after 1 clk, data_to_show=32'h12345678 after 2 clk, dwell_done pulses every 4 cycles while req is held.
- req=4'b1111 held, data words 32'hA,B,C,D → grant sequence 0,1,2,3,0 with exactly 4 cycles per grant; dwell_done coincides with each switch.
- Grant source 1, drop req[1] after 1 cycle → grant stays 4'b0010 until expiry, then IDLE with data_to_show=0 and grant=0.
- auto_cycle=1, req=0 → all four sources are displayed in turn. Assert freeze for 10 cycles mid-dwell → no change in grant, data_to_show or counter; the remaining dwell resumes exactly after freeze drops.
- Assert rst_n low asynchronously (between clock edges) during source 2's dwell → outputs are 0 immediately. After release with req=4'b1111, the first grant is source 0.
- DWELL_TICKS=2, req toggling on the expiry cycle → the new request is chosen on that same edge; no cycle shows grant=0.
